mc_stage_controller: RTL

Multi-cycle sequencer that drives the existing fetch/decode/execute/memory/writeback stage datapath one instruction at a time through a shared instruction and data memory port. It consumes decode outputs (mem_op, reg_we, illegal) and generates the stage enables, memory request handshakes, register-file write strobe and PC update strobe. It also detects bus timeouts and illegal encodings, parks the core in a sticky trap state, and keeps a retired-instruction counter.

---
 rtl/mc_stage_controller.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mc_stage_controller.sv
// Multi-cycle sequencer for the F/D/E/M/W stage datapath: stage strobes, memory
// handshakes, bus-timeout and illegal-encoding trap, retired-instruction counter.
module mc_stage_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_en,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    input  logic [1:0]       dec_mem_op,
    input  logic             dec_reg_we,
    input  logic             dec_illegal,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_we,
    output logic             reg_we_out,
    output logic             pc_we,
    output logic [2:0]       state,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retire_count
);

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEMORY    = 3'd3,
        WRITEBACK = 3'd4,
        TRAP      = 3'd5,
        BOOT      = 3'd7
    } state_e;

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
    localparam logic [1:0] CAUSE_MEMOP   = 2'b11;

    state_e             state_q, state_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [1:0]         cause_q, cause_d;
    logic [CNT_W-1:0]   retire_q, retire_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        tmo_d      = tmo_q;
        cause_d    = cause_q;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_we      = 1'b0;
        reg_we_out = 1'b0;
        pc_we      = 1'b0;

        unique case (state_q)
            BOOT: begin
                state_d = FETCH;
                tmo_d   = '0;
            end
            FETCH: begin
                // A nonzero wait count means a fetch is already outstanding and must be held.
                imem_req = run_en || (tmo_q != '0);
                if (imem_req) begin
                    if (imem_ack) begin
                        ir_we   = 1'b1;
                        state_d = DECODE;
                    end else if (tmo_q == TMO_LAST) begin
                        state_d = TRAP;
                        cause_d = CAUSE_TIMEOUT;
                    end else begin
                        tmo_d = tmo_q + TMO_ONE;
                    end
                end
            end
            DECODE: begin
                if (dec_illegal) begin
                    state_d = TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else if (dec_mem_op == 2'b11) begin
                    state_d = TRAP;
                    cause_d = CAUSE_MEMOP;
                end else begin
                    state_d = EXECUTE;
                end
            end
            EXECUTE: begin
                if (dec_mem_op == 2'b01 || dec_mem_op == 2'b10) begin
                    state_d = MEMORY;
                    tmo_d   = '0;
                end else if (dec_reg_we) begin
                    state_d = WRITEBACK;
                end else begin
                    pc_we   = 1'b1;
                    state_d = FETCH;
                    tmo_d   = '0;
                end
            end
            MEMORY: begin
                dmem_req = 1'b1;
                dmem_we  = (dec_mem_op == 2'b10);
                if (dmem_ack) begin
                    if (dmem_we) begin
                        pc_we   = 1'b1;
                        state_d = FETCH;
                        tmo_d   = '0;
                    end else begin
                        state_d = WRITEBACK;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                end
            end
            WRITEBACK: begin
                reg_we_out = 1'b1;
                pc_we      = 1'b1;
                state_d    = FETCH;
                tmo_d      = '0;
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = TRAP;
                cause_d = CAUSE_ILLEGAL;
            end
        endcase

        retire_d = pc_we ? retire_q + CNT_ONE : retire_q;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= BOOT;
            tmo_q    <= '0;
            cause_q  <= 2'b00;
            retire_q <= '0;
        end else begin
            state_q  <= state_d;
            tmo_q    <= tmo_d;
            cause_q  <= cause_d;
            retire_q <= retire_d;
        end
    end

    assign state        = state_q;
    assign trap         = (state_q == TRAP);
    assign trap_cause   = cause_q;
    assign retire_count = retire_q;

endmodule
